dcm_drp_arbiter: RTL and testbench
==================================

# dcm_drp_arbiter

Round-robin arbiter sharing the single DCM dynamic-reconfiguration port (DRP) between up to N_REQ requesters: the frequency-change sequencer, status pollers and the host register bridge. Each request is one DRP access (read or write); a requester may lock the port across a multi-access read-modify-write sequence so the 50h/41h/51h updates are never interleaved. A watchdog terminates accesses whose `drdy` never arrives. Sits directly in front of the DCM primitive's DRP pins.

## Interface
- `N_REQ`, 2: number of requesters (1..8).
- `TIMEOUT`, 255: maximum cycles in WAIT before forced error completion (1..65535).
- `clock`  in  1  single system clock; DRP clock is the same clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_strobe`  in  N_REQ  one-cycle access request per requester.
- `req_we`  in  N_REQ  1 = write, 0 = read.
- `req_lock`  in  N_REQ  keep ownership after this access completes.
- `req_addr`  in  7*N_REQ  DRP address, requester i at bits [7i+6:7i].
- `req_di`  in  16*N_REQ  write data, requester i at [16i+15:16i].
- `dcm_do`  in  16  DRP read data.
- `drdy`  in  1  DRP access complete.
- `den`, `dwe`  out  1  DRP enable and write enable, one-cycle pulses.
- `daddr`  out  7  DRP address.
- `di`  out  16  DRP write data.
- `ack`  out  N_REQ  one-cycle completion pulse to the owner.
- `err`  out  1  valid with `ack`; 1 = timed out.
- `rdata`  out  16  last captured `dcm_do`, stable until the next completion.
- `owner`  out  3  index of the current or last owner.
- `state_out`  out  2  FSM state for debug.

## Operation
- Pending bit per requester: set on `req_strobe`, cleared when granted. A strobe while pending or while that requester's access is in flight is ignored; `req_we/addr/di` must be held stable from strobe to `ack`.
- States: IDLE(00), ISSUE(01), WAIT(10), HOLD(11).
- IDLE: if any pending, select a winner round-robin starting at (last owner + 1) mod N_REQ; register `owner`, `daddr`, `di`, `dwe` intent; clear the winner's pending bit -> ISSUE.
- ISSUE: `den`=1 and `dwe`=req_we for exactly one cycle; timeout counter cleared -> WAIT.
- WAIT: on `drdy`, `rdata`<=`dcm_do` (reads and writes), `ack[owner]`<=1, `err`<=0; next state HOLD if `req_lock[owner]` is high in that cycle, otherwise IDLE. If the counter reaches TIMEOUT without `drdy`: `ack[owner]`<=1, `err`<=1, `rdata` unchanged, -> IDLE, with the lock discarded.
- HOLD: only the owner may be granted. Owner pending -> latch its fields -> ISSUE. Owner `req_lock` low and no owner pending -> IDLE. Other requesters' strobes keep accumulating as pending.
- `drdy` outside WAIT is ignored. No second `den` is ever issued before `drdy` or timeout.
- `daddr`, `di` hold their last values between accesses.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, last owner N_REQ-1 (so requester 0 wins first), counter 0.
- Strobe at cycle t into an idle arbiter: grant registered at t+1, `den` at t+2, `ack` one cycle after the `drdy` cycle. Minimum round trip is strobe to `ack` = 4 cycles when `drdy` is seen at t+3.
- Locked back-to-back: strobe during HOLD -> `den` 2 cycles later.
- Timeout: `ack`+`err` one cycle after TIMEOUT WAIT cycles.
- Reset asserted mid-access: immediate return to IDLE and all outputs 0. No `ack` is produced; requesters must also reset.
- Simultaneous strobes: all are pending and served in round-robin order, one access each.

## Structure
- Shared package `dcm_drp_pkg`: state encodings, DRP address constants (ADDR_00H=7'h00, ADDR_41H=7'h41, ADDR_50H=7'h50, ADDR_51H=7'h51), `DRP_AW`=7, `DRP_DW`=16.
- Sub-module `rr_priority_select`: combinational rotate-and-priority-encode over N_REQ bits, given the pending mask and last owner; returns winner index and a valid flag.

## Test plan
- Single read: req0 strobes addr 7'h50, `drdy` 3 cycles after `den` with `dcm_do`=16'hA5C3 -> one `den`, `dwe`=0, `daddr`=50h, `ack[0]` pulse, `rdata`=A5C3, `err`=0.
- Contention: req0 and req1 strobe in the same cycle -> req0 served, then req1. Repeated simultaneous strobes alternate 1,0,1,0.
- Lock: req1 does 7'h41 read, 7'h41 write with di 16'h0004, then 7'h51 write, with `req_lock` high, while req0 strobes throughout -> req0's `den` only after req1 drops lock.
- Timeout with TIMEOUT=8: no `drdy` -> `ack[0]`=1, `err`=1 exactly 8 WAIT cycles after `den`, lock discarded, next pending served.
- Spurious `drdy` in IDLE and a duplicate strobe while pending -> no `ack`, exactly one DRP access.
- `reset_n` low during WAIT -> `den`, `ack` and `state_out` are 0 immediately. After release, a new strobe completes normally.

Source files
------------

// File: rtl/dcm_drp_pkg.sv
// Shared types and constants for the DCM DRP arbiter: FSM encodings,
// DRP bus widths and the configuration register addresses.
package dcm_drp_pkg;

  localparam int DRP_AW  = 7;
  localparam int DRP_DW  = 16;
  localparam int MAX_REQ = 8;

  localparam logic [DRP_AW-1:0] ADDR_00H = 7'h00;
  localparam logic [DRP_AW-1:0] ADDR_41H = 7'h41;
  localparam logic [DRP_AW-1:0] ADDR_50H = 7'h50;
  localparam logic [DRP_AW-1:0] ADDR_51H = 7'h51;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } drp_state_e;

  // True while an access is on the DRP and not yet completed.
  function automatic logic is_busy_state(input drp_state_e s);
    is_busy_state = (s == ST_ISSUE) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/dcm_drp_arbiter_rr.sv
// Round-robin winner selection: scans the pending mask starting one past
// the last owner and returns the first set index.
module rr_priority_select
  import dcm_drp_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [2:0]       last_i,
  output logic [2:0]       winner_o,
  output logic             valid_o
);

  logic [MAX_REQ-1:0] pend_ext;

  assign pend_ext = MAX_REQ'(pending_i);

  // Rotate-and-priority-encode, last owner gets the lowest priority.
  always_comb begin
    int   idx;
    logic hit;
    winner_o = 3'd0;
    valid_o  = 1'b0;
    idx      = 0;
    hit      = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx      = int'(last_i) + k;
      idx      = (idx >= N_REQ) ? idx - N_REQ : idx;
      hit      = !valid_o && pend_ext[idx[2:0]];
      winner_o = hit ? idx[2:0] : winner_o;
      valid_o  = valid_o | hit;
    end
  end

endmodule

// File: rtl/dcm_drp_arbiter.sv
// Shares one DCM DRP port between N_REQ requesters: round-robin grant,
// optional ownership lock for read-modify-write sequences, drdy watchdog.
module dcm_drp_arbiter
  import dcm_drp_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_strobe,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [DRP_AW*N_REQ-1:0]  req_addr,
  input  logic [DRP_DW*N_REQ-1:0]  req_di,
  input  logic [DRP_DW-1:0]        dcm_do,
  input  logic                     drdy,
  output logic                     den,
  output logic                     dwe,
  output logic [DRP_AW-1:0]        daddr,
  output logic [DRP_DW-1:0]        di,
  output logic [N_REQ-1:0]         ack,
  output logic                     err,
  output logic [DRP_DW-1:0]        rdata,
  output logic [2:0]               owner,
  output logic [1:0]               state_out
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  drp_state_e         state_q;
  logic [2:0]         owner_q;
  logic [2:0]         last_q;
  logic [N_REQ-1:0]   pending_q;
  logic [N_REQ-1:0]   pending_d;
  logic               den_q;
  logic               dwe_q;
  logic               we_q;
  logic               err_q;
  logic [N_REQ-1:0]   ack_q;
  logic [DRP_AW-1:0]  daddr_q;
  logic [DRP_DW-1:0]  di_q;
  logic [DRP_DW-1:0]  rdata_q;
  logic [15:0]        cnt_q;

  logic [DRP_AW-1:0]  addr_arr [MAX_REQ];
  logic [DRP_DW-1:0]  di_arr   [MAX_REQ];
  logic [MAX_REQ-1:0] we_ext;
  logic [MAX_REQ-1:0] lock_ext;
  logic [MAX_REQ-1:0] pend_eff_ext;
  logic [N_REQ-1:0]   owner_oh;
  logic [N_REQ-1:0]   grant_oh;
  logic [N_REQ-1:0]   inflight;
  logic [N_REQ-1:0]   accepted;
  logic [N_REQ-1:0]   pend_eff;
  logic [2:0]         sel_idx;
  logic               sel_valid;
  logic               grant_idle;
  logic               grant_hold;
  logic [2:0]         grant_idx;

  // Requester fields padded to MAX_REQ so a 3-bit index is always in range.
  for (genvar g = 0; g < MAX_REQ; g++) begin : g_unpack
    if (g < N_REQ) begin : g_used
      assign addr_arr[g] = req_addr[DRP_AW*g +: DRP_AW];
      assign di_arr[g]   = req_di[DRP_DW*g +: DRP_DW];
    end else begin : g_pad
      assign addr_arr[g] = '0;
      assign di_arr[g]   = '0;
    end
  end

  assign we_ext   = MAX_REQ'(req_we);
  assign lock_ext = MAX_REQ'(req_lock);

  // A strobe is taken only if that requester is neither pending nor on the bus.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (owner_q == 3'(i));
    end
    if (is_busy_state(state_q)) begin
      inflight = owner_oh;
    end else begin
      inflight = '0;
    end
    accepted = req_strobe & ~pending_q & ~inflight;
    pend_eff = pending_q | accepted;
  end

  rr_priority_select #(
    .N_REQ (N_REQ)
  ) u_rr (
    .pending_i (pend_eff),
    .last_i    (last_q),
    .winner_o  (sel_idx),
    .valid_o   (sel_valid)
  );

  // In HOLD only the locking owner can be granted; others keep accumulating.
  always_comb begin
    pend_eff_ext = MAX_REQ'(pend_eff);
    grant_hold   = (state_q == ST_HOLD) && pend_eff_ext[owner_q];
    grant_idle   = (state_q == ST_IDLE) && sel_valid;
    if (grant_hold) begin
      grant_idx = owner_q;
    end else begin
      grant_idx = sel_idx;
    end
    grant_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_oh[i] = (grant_idx == 3'(i));
    end
    if (grant_idle || grant_hold) begin
      pending_d = pend_eff & ~grant_oh;
    end else begin
      pending_d = pend_eff;
    end
  end

  // Arbiter FSM with all DRP-side and requester-side outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 3'd0;
      last_q    <= 3'(N_REQ - 1);
      pending_q <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= '0;
      daddr_q   <= '0;
      di_q      <= '0;
      rdata_q   <= '0;
      cnt_q     <= 16'd0;
    end else begin
      pending_q <= pending_d;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      if (grant_idle || grant_hold) begin
        owner_q <= grant_idx;
        last_q  <= grant_idx;
        daddr_q <= addr_arr[grant_idx];
        di_q    <= di_arr[grant_idx];
        we_q    <= we_ext[grant_idx];
      end
      case (state_q)
        ST_IDLE: begin
          if (grant_idle) begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          den_q   <= 1'b1;
          dwe_q   <= we_q;
          cnt_q   <= 16'd0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drdy) begin
            rdata_q <= dcm_do;
            ack_q   <= owner_oh;
            err_q   <= 1'b0;
            state_q <= lock_ext[owner_q] ? ST_HOLD : ST_IDLE;
          end else if (cnt_q == TO_LAST) begin
            // Watchdog expiry: complete with error and drop any lock.
            ack_q   <= owner_oh;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_HOLD: begin
          if (grant_hold) begin
            state_q <= ST_ISSUE;
          end else if (!lock_ext[owner_q]) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign den       = den_q;
  assign dwe       = dwe_q;
  assign daddr     = daddr_q;
  assign di        = di_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_dcm_drp_arbiter.sv
// Directed bench for dcm_drp_arbiter with two requesters and an 8-cycle
// watchdog; expected values are worked out by hand from the cycle timing.
module tb_dcm_drp_arbiter;
  import dcm_drp_pkg::*;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  req_strobe = 2'b00;
  logic [1:0]  req_we     = 2'b00;
  logic [1:0]  req_lock   = 2'b00;
  logic [13:0] req_addr   = 14'd0;
  logic [31:0] req_di     = 32'd0;
  logic [15:0] dcm_do     = 16'd0;
  logic        drdy       = 1'b0;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [1:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic [2:0]  owner;
  logic [1:0]  state_out;

  int          total    = 0;
  int          bad      = 0;
  int          den_cnt  = 0;
  int          ack0_cnt = 0;
  int          ack1_cnt = 0;
  logic [15:0] last_data = 16'd0;

  always #5 clock = ~clock;

  dcm_drp_arbiter #(
    .N_REQ   (2),
    .TIMEOUT (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_strobe (req_strobe),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_di     (req_di),
    .dcm_do     (dcm_do),
    .drdy       (drdy),
    .den        (den),
    .dwe        (dwe),
    .daddr      (daddr),
    .di         (di),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .owner      (owner),
    .state_out  (state_out)
  );

  // Event counters sampled mid-cycle.
  always @(negedge clock) begin
    if (den)    den_cnt  <= den_cnt + 1;
    if (ack[0]) ack0_cnt <= ack0_cnt + 1;
    if (ack[1]) ack1_cnt <= ack1_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle step; strobes are single-cycle pulses.
  task automatic tick();
    @(negedge clock);
    #1;
    req_strobe = 2'b00;
  endtask

  task automatic set_req(input int r, input logic we, input logic lk,
                         input logic [6:0] a, input logic [15:0] d);
    req_we[r +: 1]      = we;
    req_lock[r +: 1]    = lk;
    req_addr[7*r +: 7]  = a;
    req_di[16*r +: 16]  = d;
  endtask

  // Wait for den, check the issued access, answer with drdy after lat cycles.
  task automatic serve(input string tag, input int exp_wait, input int exp_own,
                       input logic [6:0] exp_addr, input logic exp_we,
                       input logic [15:0] exp_di, input int lat, input logic [15:0] data);
    int         w;
    logic [1:0] exp_ack;
    w = 0;
    while (den !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    if (den !== 1'b1) begin
      chk({tag, "_den_seen"}, 32'(den), 32'd1);
      return;
    end
    if (exp_wait >= 0) chk({tag, "_den_lat"}, 32'(w), 32'(exp_wait));
    chk({tag, "_owner"}, 32'(owner), 32'(exp_own));
    chk({tag, "_daddr"}, 32'(daddr), 32'(exp_addr));
    chk({tag, "_dwe"}, 32'(dwe), 32'(exp_we));
    if (exp_we) chk({tag, "_di"}, 32'(di), 32'(exp_di));
    repeat (lat) tick();
    drdy   = 1'b1;
    dcm_do = data;
    tick();
    drdy   = 1'b0;
    dcm_do = 16'd0;
    exp_ack = 2'(1 << exp_own);
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'(data));
    last_data = data;
  endtask

  initial begin
    int d0;
    int a0;

    repeat (3) tick();
    chk("rst_den", 32'(den), 32'd0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    chk("rst_daddr", 32'(daddr), 32'd0);
    chk("rst_di", 32'(di), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single read of 50h, drdy three cycles after den.
    d0 = den_cnt;
    set_req(0, 1'b0, 1'b0, ADDR_50H, 16'h0000);
    req_strobe = 2'b01;
    serve("rd", 2, 0, ADDR_50H, 1'b0, 16'h0000, 3, 16'hA5C3);
    chk("rd_state", 32'(state_out), 32'd0);
    tick();
    chk("rd_ack_pulse", 32'(ack), 32'd0);
    repeat (4) tick();
    chk("rd_den_cnt", 32'(den_cnt - d0), 32'd1);

    // Simultaneous strobes after req0 was last owner: 1,0,1,0.
    set_req(0, 1'b0, 1'b0, ADDR_00H, 16'h0000);
    set_req(1, 1'b0, 1'b0, ADDR_41H, 16'h0000);
    a0 = ack0_cnt + ack1_cnt;
    for (int i = 0; i < 2; i++) begin
      req_strobe = 2'b11;
      serve($sformatf("rr%0d_a", i), 2, 1, ADDR_41H, 1'b0, 16'h0000, 1, 16'(16'h1100 + i));
      serve($sformatf("rr%0d_b", i), 2, 0, ADDR_00H, 1'b0, 16'h0000, 1, 16'(16'h2200 + i));
    end
    chk("rr_ack_cnt", 32'(ack0_cnt + ack1_cnt - a0), 32'd4);

    // Locked read-modify-write by req1 while req0 waits.
    set_req(1, 1'b0, 1'b1, ADDR_41H, 16'h0000);
    req_strobe = 2'b11;
    serve("lk_rd", 2, 1, ADDR_41H, 1'b0, 16'h0000, 1, 16'h0010);
    chk("lk_hold", 32'(state_out), 32'd3);
    set_req(1, 1'b1, 1'b1, ADDR_41H, 16'h0004);
    req_strobe = 2'b11;
    serve("lk_wr41", 2, 1, ADDR_41H, 1'b1, 16'h0004, 1, 16'h0014);
    set_req(1, 1'b1, 1'b1, ADDR_51H, 16'h1234);
    req_strobe = 2'b11;
    serve("lk_wr51", 2, 1, ADDR_51H, 1'b1, 16'h1234, 1, 16'h0000);
    d0 = den_cnt;
    repeat (5) tick();
    chk("lk_hold_noden", 32'(den_cnt - d0), 32'd0);
    chk("lk_hold_state", 32'(state_out), 32'd3);
    set_req(1, 1'b0, 1'b0, ADDR_51H, 16'h0000);
    serve("lk_rel", 3, 0, ADDR_00H, 1'b0, 16'h0000, 2, 16'h5A5A);

    // Watchdog: req0 locked read never answered, req1 queued behind it.
    set_req(0, 1'b0, 1'b1, ADDR_00H, 16'h0000);
    req_strobe = 2'b01;
    tick();
    set_req(1, 1'b0, 1'b0, ADDR_50H, 16'h0000);
    req_strobe = 2'b10;
    tick();
    chk("to_den", 32'(den), 32'd1);
    chk("to_owner", 32'(owner), 32'd0);
    repeat (7) tick();
    chk("to_early", 32'(ack), 32'd0);
    tick();
    chk("to_ack", 32'(ack), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_state", 32'(state_out), 32'd0);
    chk("to_rdata", 32'(rdata), 32'(last_data));
    set_req(0, 1'b0, 1'b0, ADDR_00H, 16'h0000);
    serve("to_next", 2, 1, ADDR_50H, 1'b0, 16'h0000, 1, 16'h0F0F);

    // Spurious drdy while idle.
    d0 = den_cnt;
    a0 = ack0_cnt + ack1_cnt;
    drdy   = 1'b1;
    dcm_do = 16'hFFFF;
    tick();
    tick();
    drdy   = 1'b0;
    dcm_do = 16'h0000;
    tick();
    chk("sp_ack", 32'(ack0_cnt + ack1_cnt - a0), 32'd0);
    chk("sp_rdata", 32'(rdata), 32'(last_data));
    chk("sp_state", 32'(state_out), 32'd0);
    chk("sp_den", 32'(den_cnt - d0), 32'd0);

    // Duplicate strobes from req0 while it is pending behind req1.
    d0 = den_cnt;
    a0 = ack0_cnt;
    set_req(1, 1'b0, 1'b0, ADDR_51H, 16'h0000);
    set_req(0, 1'b0, 1'b0, ADDR_00H, 16'h0000);
    req_strobe = 2'b10;
    tick();
    req_strobe = 2'b01;
    tick();
    req_strobe = 2'b01;
    serve("dup_a", -1, 1, ADDR_51H, 1'b0, 16'h0000, 1, 16'h0101);
    serve("dup_b", 2, 0, ADDR_00H, 1'b0, 16'h0000, 1, 16'h0202);
    repeat (6) tick();
    chk("dup_den_cnt", 32'(den_cnt - d0), 32'd2);
    chk("dup_ack0_cnt", 32'(ack0_cnt - a0), 32'd1);

    // Reset asserted in the den cycle of an access.
    a0 = ack0_cnt + ack1_cnt;
    set_req(0, 1'b0, 1'b0, ADDR_41H, 16'h0000);
    req_strobe = 2'b01;
    tick();
    tick();
    chk("rw_pre_den", 32'(den), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_den", 32'(den), 32'd0);
    chk("rw_state", 32'(state_out), 32'd0);
    chk("rw_ack", 32'(ack), 32'd0);
    chk("rw_daddr", 32'(daddr), 32'd0);
    tick();
    tick();
    chk("rw_no_ack", 32'(ack0_cnt + ack1_cnt - a0), 32'd0);
    reset_n = 1'b1;
    tick();

    // After reset req0 wins a simultaneous request first.
    set_req(1, 1'b0, 1'b0, ADDR_51H, 16'h0000);
    req_strobe = 2'b11;
    serve("post_a", 2, 0, ADDR_41H, 1'b0, 16'h0000, 1, 16'h3C3C);
    serve("post_b", 2, 1, ADDR_51H, 1'b0, 16'h0000, 3, 16'hC3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
